// File: rtl/pkt_scheduler.sv
// Packet scheduler: one strict-priority urgent FIFO in front of NUM_FLOWS
// per-flow FIFOs that are served round-robin. Upstream pushes through a
// ready/enable handshake. Downstream pulls at most one packet per cycle.
module pkt_scheduler #(
  parameter int DWIDTH    = 32,
  parameter int INFO_W    = 32,
  parameter int NUM_FLOWS = 4,
  parameter int DEPTH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              in_valid,
  input  logic              in_enque_en,
  input  logic              in_ugr_en,
  input  logic [INFO_W-1:0] in_pkt_info,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_deque_en,
  output logic [DWIDTH-1:0] out_data
);

  localparam int FW = $clog2(NUM_FLOWS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [FW-1:0] FLOW_ONE = FW'(1);

  // Storage (no reset: contents are qualified by the occupancy counters)
  logic [DWIDTH-1:0] r_urgMem  [DEPTH];
  logic [DWIDTH-1:0] r_flowMem [NUM_FLOWS][DEPTH];

  // Urgent queue bookkeeping
  logic [AW-1:0] r_urgWr;
  logic [AW-1:0] r_urgRd;
  logic [CW-1:0] r_urgCnt;

  // Flow queue bookkeeping
  logic [AW-1:0] r_flowWr  [NUM_FLOWS];
  logic [AW-1:0] r_flowRd  [NUM_FLOWS];
  logic [CW-1:0] r_flowCnt [NUM_FLOWS];

  // Round-robin pointer and registered outputs
  logic [FW-1:0]     r_rrPtr;
  logic              r_inValid;
  logic              r_outValid;
  logic [DWIDTH-1:0] r_outData;

  // Combinational control
  logic                 w_allFree;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pushUrg;
  logic                 w_pushFlow;
  logic [FW-1:0]        w_pushId;
  logic                 w_urgNonEmpty;
  logic                 w_flowHit;
  logic [FW-1:0]        w_flowSel;
  logic [FW-1:0]        w_scanIdx;
  logic                 w_popUrg;
  logic                 w_popFlow;
  logic [NUM_FLOWS-1:0] w_flowPush;
  logic [NUM_FLOWS-1:0] w_flowPop;
  logic                 w_unusedInfoBits;

  // Only the low bits of the header info select the flow
  assign w_pushId         = in_pkt_info[FW-1:0];
  assign w_unusedInfoBits = ^in_pkt_info[INFO_W-1:FW];

  // Conservative backpressure: accept only when every queue has a free slot
  always_comb begin
    w_allFree = (r_urgCnt != FULL_CNT);
    for (int f = 0; f < NUM_FLOWS; f++) begin
      if (r_flowCnt[f] == FULL_CNT) begin
        w_allFree = 1'b0;
      end
    end
  end

  assign w_ready    = rst && w_allFree;
  assign w_push     = in_enque_en && w_ready;
  assign w_pushUrg  = w_push && in_ugr_en;
  assign w_pushFlow = w_push && !in_ugr_en;

  assign w_urgNonEmpty = (r_urgCnt != '0);

  // Find the first non-empty flow at or after the RR pointer, with wrap
  always_comb begin
    w_flowHit = 1'b0;
    w_flowSel = '0;
    w_scanIdx = '0;
    for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
      w_scanIdx = r_rrPtr + FW'(i);
      if (r_flowCnt[w_scanIdx] != '0) begin
        w_flowHit = 1'b1;
        w_flowSel = w_scanIdx;
      end
    end
  end

  assign w_popUrg  = out_deque_en && w_urgNonEmpty;
  assign w_popFlow = out_deque_en && !w_urgNonEmpty && w_flowHit;

  // Per-flow push/pop strobes
  always_comb begin
    w_flowPush = '0;
    w_flowPop  = '0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      w_flowPush[f] = w_pushFlow && (w_pushId == FW'(f));
      w_flowPop[f]  = w_popFlow && (w_flowSel == FW'(f));
    end
  end

  // Write incoming packet data into the selected queue storage
  always_ff @(posedge clk) begin
    if (w_pushUrg) begin
      r_urgMem[r_urgWr] <= in_data;
    end
    if (w_pushFlow) begin
      r_flowMem[w_pushId][r_flowWr[w_pushId]] <= in_data;
    end
  end

  // Urgent queue pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_urgWr  <= '0;
      r_urgRd  <= '0;
      r_urgCnt <= '0;
    end else begin
      if (w_pushUrg) begin
        r_urgWr <= r_urgWr + PTR_ONE;
      end
      if (w_popUrg) begin
        r_urgRd <= r_urgRd + PTR_ONE;
      end
      unique case ({w_pushUrg, w_popUrg})
        2'b10:   r_urgCnt <= r_urgCnt + CNT_ONE;
        2'b01:   r_urgCnt <= r_urgCnt - CNT_ONE;
        default: r_urgCnt <= r_urgCnt;
      endcase
    end
  end

  // Flow queue pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        r_flowWr[f]  <= '0;
        r_flowRd[f]  <= '0;
        r_flowCnt[f] <= '0;
      end
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (w_flowPush[f]) begin
          r_flowWr[f] <= r_flowWr[f] + PTR_ONE;
        end
        if (w_flowPop[f]) begin
          r_flowRd[f] <= r_flowRd[f] + PTR_ONE;
        end
        unique case ({w_flowPush[f], w_flowPop[f]})
          2'b10:   r_flowCnt[f] <= r_flowCnt[f] + CNT_ONE;
          2'b01:   r_flowCnt[f] <= r_flowCnt[f] - CNT_ONE;
          default: r_flowCnt[f] <= r_flowCnt[f];
        endcase
      end
    end
  end

  // Registered output stage and round-robin pointer advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrPtr    <= '0;
      r_inValid  <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_inValid  <= w_push;
      r_outValid <= w_popUrg || w_popFlow;
      if (w_popUrg) begin
        r_outData <= r_urgMem[r_urgRd];
      end else if (w_popFlow) begin
        r_outData <= r_flowMem[w_flowSel][r_flowRd[w_flowSel]];
        r_rrPtr   <= w_flowSel + FLOW_ONE;
      end
    end
  end

  assign ready     = w_ready;
  assign in_valid  = r_inValid;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;

endmodule

// File: tb/tb_pkt_scheduler.sv
// Testbench for pkt_scheduler: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model of the scheduler.
module tb_pkt_scheduler;

  localparam int DW = 32;
  localparam int IW = 32;
  localparam int NF = 4;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic          ready;
  logic          in_valid;
  logic          in_enque_en;
  logic          in_ugr_en;
  logic [IW-1:0] in_pkt_info;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_deque_en;
  logic [DW-1:0] out_data;

  int total;
  int bad;

  // Behavioural model: plain queues, one per traffic class
  logic [DW-1:0] mUrg[$];
  logic [DW-1:0] mFlow[NF][$];
  int            mRr;
  logic          mExpValid;
  logic [DW-1:0] mExpData;
  int            dutOutCount;

  pkt_scheduler #(
    .DWIDTH(DW), .INFO_W(IW), .NUM_FLOWS(NF), .DEPTH(DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .in_valid(in_valid),
    .in_enque_en(in_enque_en),
    .in_ugr_en(in_ugr_en),
    .in_pkt_info(in_pkt_info),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_deque_en(out_deque_en),
    .out_data(out_data)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic modelReady();
    if (mUrg.size() >= DP) return 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (mFlow[f].size() >= DP) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic clearModel();
    mUrg.delete();
    for (int f = 0; f < NF; f++) mFlow[f].delete();
    mRr       = 0;
    mExpValid = 1'b0;
    mExpData  = '0;
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1
  task automatic applyStimulus(input logic en, input logic ugr, input logic [IW-1:0] info,
                               input logic [DW-1:0] data, input logic deq);
    logic acc;
    logic found;
    int   f;
    in_enque_en  = en;
    in_ugr_en    = ugr;
    in_pkt_info  = info;
    in_data      = data;
    out_deque_en = deq;
    @(negedge clk);
    checkOutput("ready", ready, modelReady());
    acc       = en && modelReady();
    mExpValid = 1'b0;
    if (deq) begin
      if (mUrg.size() > 0) begin
        mExpData  = mUrg.pop_front();
        mExpValid = 1'b1;
      end else begin
        found = 1'b0;
        for (int k = 0; k < NF; k++) begin
          f = (mRr + k) % NF;
          if (!found && mFlow[f].size() > 0) begin
            found     = 1'b1;
            mExpData  = mFlow[f].pop_front();
            mExpValid = 1'b1;
            mRr       = (f + 1) % NF;
          end
        end
      end
    end
    if (acc) begin
      if (ugr) mUrg.push_back(data);
      else     mFlow[int'(info[1:0])].push_back(data);
    end
    @(posedge clk);
    #1;
    checkOutput("in_valid", in_valid, acc);
    checkOutput("out_valid", out_valid, mExpValid);
    checkOutput("out_data", out_data, mExpData);
    if (out_valid === 1'b1) dutOutCount++;
  endtask

  task automatic idle(input logic deq, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, deq);
  endtask

  // Hold reset low for three cycles, checking outputs, then release
  task automatic resetDut();
    rst          = 1'b0;
    in_enque_en  = 1'b0;
    in_ugr_en    = 1'b0;
    in_pkt_info  = '0;
    in_data      = '0;
    out_deque_en = 1'b0;
    clearModel();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", ready, 1'b0);
      checkOutput("rst_in_valid", in_valid, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_data", out_data, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ready_after_rst", ready, 1'b1);
  endtask

  task automatic randomTraffic(input int cycles, input int deqPct);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(($urandom % 100) < 75, ($urandom % 100) < 15, $urandom, $urandom,
                    ($urandom % 100) < deqPct);
    end
  endtask

  logic [DW-1:0] urgExp [3];

  initial begin
    total       = 0;
    bad         = 0;
    dutOutCount = 0;
    rst         = 1'b1;
    #2;
    resetDut();

    // Single normal packet
    applyStimulus(1'b1, 1'b0, 32'h114515, 32'h115, 1'b0);
    checkOutput("single_in_valid", in_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("single_out_valid", out_valid, 1'b1);
    checkOutput("single_out_data", out_data, 32'h115);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("single_out_drop", out_valid, 1'b0);

    // Urgent overtakes flow packets queued earlier
    applyStimulus(1'b1, 1'b0, 32'h114516, 32'h116, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h114517, 32'h117, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h114518, 32'h11D, 1'b0);
    urgExp[0] = 32'h11D;
    urgExp[1] = 32'h116;
    urgExp[2] = 32'h117;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("urgent_order", out_data, urgExp[j]);
    end
    idle(1'b1, 2);

    // Round-robin across four flows, two packets each
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h114514 + (k % 4), 32'h114 + k, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("rr_order", out_data, 32'h114 + j);
    end
    idle(1'b1, 2);

    // Fill flow 0, check drop and recovery
    for (int k = 0; k < DP; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h114514, 32'h200 + k, 1'b0);
    end
    checkOutput("full_ready", ready, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h114514, 32'h2FF, 1'b0);
    checkOutput("drop_in_valid", in_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("ready_restored", ready, 1'b1);
    idle(1'b1, DP + 2);

    // Streaming with interleaved urgent packets
    dutOutCount = 0;
    for (int n = 0; n < 65; n++) begin
      applyStimulus(1'b1, ((n % 10) == 0) || ((n % 10) == 9), 32'h114514 + (n % 4),
                    32'h114 + n, 1'b1);
    end
    idle(1'b1, 70);
    checkOutput("stream_out_count", dutOutCount, 65);

    // Randomized traffic at several drain rates
    randomTraffic(200, 20);
    randomTraffic(200, 60);
    randomTraffic(150, 30);

    // Asynchronous reset in the middle of traffic discards everything
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 1'b0);
    checkOutput("async_rst_out_data", out_data, '0);
    checkOutput("async_rst_in_valid", in_valid, 1'b0);
    resetDut();
    idle(1'b1, 4);

    randomTraffic(200, 90);
    randomTraffic(150, 40);
    idle(1'b1, 5 * DP + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_scheduler.md
Name: pkt_scheduler

Overview:
Packet scheduler with one strict-priority urgent queue and NUM_FLOWS per-flow normal queues served round-robin. Upstream pushes packets through a ready/enable interface, tagged by a header-info word and an urgent flag. Downstream pulls one packet per cycle with a dequeue enable. Sits between the packet parser and the egress port.

Parameters:
DWIDTH, 32, packet data/descriptor width
INFO_W, 32, header-info width (pkHeadInfo)
NUM_FLOWS, 4, number of normal flow queues (power of 2)
DEPTH, 16, entries per queue (power of 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
ready  out  1  scheduler can accept an enqueue this cycle
in_valid  out  1  one-cycle pulse: an enqueue was accepted on the previous edge
in_enque_en  in  1  enqueue request
in_ugr_en  in  1  packet is urgent (qualified by in_enque_en)
in_pkt_info  in  INFO_W  header info; flow id = in_pkt_info[log2(NUM_FLOWS)-1:0]
in_data  in  DWIDTH  packet data
out_valid  out  1  out_data holds a dequeued packet this cycle
out_deque_en  in  1  downstream permits a dequeue
out_data  out  DWIDTH  dequeued packet data

Behaviour:
- Reset (rst low, asynchronous): all queues empty, RR pointer=0, ready=0, in_valid=0, out_valid=0, out_data=0. Reset mid-operation discards all stored packets.
- ready is combinational: 1 when out of reset and every queue (urgent and all flows) has at least one free slot; otherwise 0. Conservative rule; no per-queue backpressure.
- Enqueue accepted at a rising edge when in_enque_en && ready. in_ugr_en=1 -> push in_data to urgent queue. Otherwise push to flow queue in_pkt_info[1:0] (for NUM_FLOWS=4). Upper info bits are ignored.
- in_enque_en while ready=0: dropped silently, no state change, in_valid stays 0.
- in_valid is registered and equals 1 in the cycle after an accepted enqueue.
- Dequeue decision at each rising edge when out_deque_en=1, using queue occupancy before that edge:
  - Urgent queue non-empty -> pop urgent head.
  - Else, if any flow queue is non-empty, pop the first non-empty flow scanning from RR pointer upward with wrap; RR pointer becomes served flow+1 mod NUM_FLOWS.
  - All queues empty -> out_valid=0.
- out_valid/out_data are registered and valid for exactly the cycle after the pop. out_data holds its last value when out_valid=0. out_deque_en=0 -> out_valid=0, nothing popped, RR pointer unchanged.
- No bypass: a packet written at edge N is earliest selectable at edge N+1 and appears on out_data after edge N+1 (min latency 2 edges from presentation).
- Simultaneous push and pop on the same queue in one cycle is legal; count unchanged; FIFO order preserved within each queue.
- Pointers wrap modulo DEPTH. Occupancy counters are log2(DEPTH)+1 bits wide to distinguish full from empty.
- Urgent traffic can starve flows; intended behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> ready=0 during reset, ready=1 on the first cycle after release; out_valid=0, out_data=0.
- Single normal packet: in_data=0x115, info=0x114515, ugr=0, out_deque_en=0 at enqueue -> in_valid=1 next cycle; after out_deque_en=1, out_valid=1 with out_data=0x115 for exactly one cycle, then out_valid=0.
- Urgent priority: enqueue flow packets 0x116 (info 0x114516) and 0x117 (0x114517), then urgent 0x11D (ugr=1) with out_deque_en=0; then raise deque -> output order 0x11D, 0x116, 0x117.
- Round-robin: with out_deque_en=0 enqueue 2 packets in each of flows 0..3 (data = 0x114+k, info = 0x114514+k%4); then dequeue -> flows served 0,1,2,3,0,1,2,3, FIFO order within each flow.
- Full/backpressure: out_deque_en=0, push DEPTH packets to flow 0 -> ready drops to 0 after the 16th accept; a 17th push is dropped (in_valid=0); one dequeue restores ready=1.
- Streaming: out_deque_en=1, 65 back-to-back packets, data=0x114+n, info=0x114514+n%4, ugr when n%10 in {0,9} -> every packet is output exactly once, no loss or duplication; urgent packets are never delayed behind flow packets queued earlier.
